// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - loadable synchronous-read instruction memory with clear sweep
module instr_mem_sync #(
   parameter int                WORD_W   = 32,
   parameter int                DEPTH    = 64,
   parameter int                ADDR_W   = 32,
   parameter logic [WORD_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              freeze,
   input  logic              flush,
   input  logic [ADDR_W-1:0] address,
   output logic [WORD_W-1:0] instruction,
   output logic              instr_valid,
   output logic              misaligned,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data,
   output logic              ready
);

   localparam int                IDX_W      = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [WORD_W-1:0]  instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               mis_q, mis_d;
   logic [WORD_W-1:0]  mem_q [DEPTH];

   logic [IDX_W-1:0]   rd_idx, ld_idx, mem_waddr;
   logic [WORD_W-1:0]  mem_wdata, rd_word;
   logic               mem_we, rd_aligned, rd_in_range, ld_ok;

   assign rd_idx      = address[IDX_W+1:2];
   assign ld_idx      = ld_addr[IDX_W+1:2];
   assign rd_aligned  = (address[1:0] == 2'b00);
   assign rd_in_range = (address < ADDR_LIMIT);
   assign ld_ok       = ld_en && (ld_addr[1:0] == 2'b00) && (ld_addr < ADDR_LIMIT);

   // Write-first: a same-cycle load to the fetched word is forwarded to the read.
   assign rd_word = (ld_ok && (ld_idx == rd_idx)) ? ld_data : mem_q[rd_idx];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      mis_d     = mis_q;
      mem_we    = 1'b0;
      mem_waddr = ld_idx;
      mem_wdata = ld_data;
      case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = NOP_WORD;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            mem_we = ld_ok;
            if (flush) begin
               instr_d = NOP_WORD;
               valid_d = 1'b0;
               mis_d   = 1'b0;
            end else if (freeze) begin
               instr_d = instr_q;
            end else if (rd_en && rd_aligned && rd_in_range) begin
               instr_d = rd_word;
               valid_d = 1'b1;
               mis_d   = 1'b0;
            end else begin
               // Misaligned, out-of-range and idle cycles all yield an invalid NOP.
               instr_d = NOP_WORD;
               valid_d = 1'b0;
               mis_d   = rd_en && !rd_aligned;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign misaligned  = mis_q;
   assign ready       = (state_q == S_RUN);

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - self-checking bench for instr_mem_sync
module tb_instr_mem_sync;

   localparam int DEPTH = 64;
   localparam logic [31:0] NOP = 32'h0;

   logic        clk = 1'b0;
   logic        rst, rd_en, freeze, flush, ld_en;
   logic [31:0] address, ld_addr, ld_data;
   logic [31:0] instruction;
   logic        instr_valid, misaligned, ready;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural reference state
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_instr;
   logic        m_valid, m_mis, m_run;
   int          m_sweep;

   typedef struct {
      logic        rd_en, freeze, flush, ld_en;
      logic [31:0] address, ld_addr, ld_data;
      logic [31:0] e_instr;
      logic        e_valid, e_mis;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   instr_mem_sync dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .freeze(freeze), .flush(flush),
      .address(address), .instruction(instruction), .instr_valid(instr_valid),
      .misaligned(misaligned), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ready(ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic [31:0] w;
      logic        wr_ok;
      wr_ok = ld_en && (ld_addr % 4 == 0) && (ld_addr < 4 * DEPTH);
      if (rst) begin
         m_instr = NOP; m_valid = 0; m_mis = 0; m_run = 0; m_sweep = 0;
      end else if (!m_run) begin
         m_sweep++;
         if (m_sweep == DEPTH) begin
            m_run = 1;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
         end
      end else begin
         if (flush) begin
            m_instr = NOP; m_valid = 0; m_mis = 0;
         end else if (freeze) begin
            // outputs hold
         end else if (rd_en && (address % 4 != 0)) begin
            m_instr = NOP; m_valid = 0; m_mis = 1;
         end else if (rd_en && (address >= 4 * DEPTH)) begin
            m_instr = NOP; m_valid = 0; m_mis = 0;
         end else if (rd_en) begin
            w = m_mem[address / 4];
            if (wr_ok && (ld_addr / 4 == address / 4)) w = ld_data;
            m_instr = w; m_valid = 1; m_mis = 0;
         end else begin
            m_instr = NOP; m_valid = 0; m_mis = 0;
         end
         if (wr_ok) m_mem[ld_addr / 4] = ld_data;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("model_instr", instruction, m_instr);
      chk("model_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("model_mis",   {31'b0, misaligned},  {31'b0, m_mis});
      chk("model_ready", {31'b0, ready},       {31'b0, m_run});
   endtask

   task automatic idle_inputs();
      rd_en = 0; freeze = 0; flush = 0; ld_en = 0;
      address = 0; ld_addr = 0; ld_data = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_instr"}, instruction, NOP);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
      chk({tag, "_mis"},   {31'b0, misaligned},  32'd0);
      chk({tag, "_ready"}, {31'b0, ready},       32'd0);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic fetch(input logic [31:0] a);
      idle_inputs();
      rd_en = 1; address = a;
      tick();
   endtask

   task automatic add_vec(input logic r, input logic fz, input logic fl, input logic [31:0] a,
                          input logic l, input logic [31:0] la, input logic [31:0] ld,
                          input logic [31:0] ei, input logic ev, input logic em);
      vec_t v;
      v.rd_en = r; v.freeze = fz; v.flush = fl; v.address = a;
      v.ld_en = l; v.ld_addr = la; v.ld_data = ld;
      v.e_instr = ei; v.e_valid = ev; v.e_mis = em;
      vecs.push_back(v);
   endtask

   initial begin
      int n;
      logic seen_valid;

      add_vec(0, 0, 0,   0, 1,   0, 32'hE3A00014, NOP,          0, 0);
      add_vec(0, 0, 0,   0, 1,   4, 32'hE3A01A01, NOP,          0, 0);
      add_vec(1, 0, 0,   0, 0,   0, 0,            32'hE3A00014, 1, 0);
      add_vec(1, 0, 0,   4, 0,   0, 0,            32'hE3A01A01, 1, 0);
      add_vec(1, 0, 0,   8, 0,   0, 0,            NOP,          1, 0);
      add_vec(1, 0, 0,   6, 0,   0, 0,            NOP,          0, 1);
      add_vec(1, 0, 0, 256, 0,   0, 0,            NOP,          0, 0);
      add_vec(1, 0, 0,   4, 0,   0, 0,            32'hE3A01A01, 1, 0);
      add_vec(1, 1, 0,   8, 0,   0, 0,            32'hE3A01A01, 1, 0);
      add_vec(1, 1, 0,   0, 1,   4, 32'h12345678, 32'hE3A01A01, 1, 0);
      add_vec(1, 1, 0,  12, 0,   0, 0,            32'hE3A01A01, 1, 0);
      add_vec(1, 1, 1,  12, 0,   0, 0,            NOP,          0, 0);
      add_vec(1, 0, 0,  12, 1,  12, 32'hE0923002, 32'hE0923002, 1, 0);
      add_vec(1, 0, 0,   4, 0,   0, 0,            32'h12345678, 1, 0);
      add_vec(1, 0, 0,   0, 1,  14, 32'hDEADBEEF, 32'hE3A00014, 1, 0);
      add_vec(1, 0, 0,  12, 1, 256, 32'hCAFEF00D, 32'hE0923002, 1, 0);
      add_vec(1, 0, 0,   6, 0,   0, 0,            NOP,          0, 1);
      add_vec(1, 1, 0,   0, 0,   0, 0,            NOP,          0, 1);
      add_vec(1, 0, 1,   0, 0,   0, 0,            NOP,          0, 0);
      add_vec(1, 0, 0, 252, 0,   0, 0,            NOP,          1, 0);
      add_vec(1, 0, 0,   0, 0,   0, 0,            32'hE3A00014, 1, 0);
      add_vec(0, 0, 0,   8, 0,   0, 0,            NOP,          0, 0);

      // Reset, then sweep must take exactly DEPTH cycles while fetches are ignored
      idle_inputs();
      rst = 1;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 0; rd_en = 1; address = 0;
      seen_valid = 0;
      n = 0;
      while (!ready && n < 200) begin
         tick();
         if (instr_valid) seen_valid = 1;
         n++;
      end
      chk("sweep_cycles", n, DEPTH);
      chk("valid_in_clear", {31'b0, seen_valid}, 32'd0);

      for (int a = 0; a < 4 * DEPTH; a += 36) begin
         fetch(a);
         chk("post_sweep_instr", instruction, NOP);
         chk("post_sweep_valid", {31'b0, instr_valid}, 32'd1);
      end

      foreach (vecs[i]) begin
         rd_en = vecs[i].rd_en; freeze = vecs[i].freeze; flush = vecs[i].flush;
         address = vecs[i].address; ld_en = vecs[i].ld_en;
         ld_addr = vecs[i].ld_addr; ld_data = vecs[i].ld_data;
         tick();
         chk($sformatf("vec%0d_instr", i), instruction, vecs[i].e_instr);
         chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("vec%0d_mis", i),   {31'b0, misaligned},  {31'b0, vecs[i].e_mis});
      end

      for (int i = 0; i < 400; i++) begin
         rd_en   = ($urandom_range(0, 3) != 0);
         freeze  = ($urandom_range(0, 3) == 0);
         flush   = ($urandom_range(0, 7) == 0);
         ld_en   = ($urandom_range(0, 2) == 0);
         address = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 4 * DEPTH + 16);
         ld_addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * DEPTH + 16)
                                               : 4 * $urandom_range(0, DEPTH - 1);
         ld_data = $urandom;
         tick();
      end

      // Reset mid-fetch in RUN, then mid-sweep at count 30 with loads attempted
      idle_inputs();
      rd_en = 1; address = 0; ld_en = 1; ld_addr = 0; ld_data = 32'hE3A00014;
      tick();
      rst = 1;
      tick();
      check_reset_outputs("rst_run");
      rst = 0; ld_addr = 8; ld_data = 32'hBADC0FFE;
      for (int i = 0; i < 30; i++) tick();
      chk("clear_ready", {31'b0, ready}, 32'd0);
      rst = 1;
      tick();
      check_reset_outputs("rst_sweep");
      rst = 0;
      wait_ready(n);
      chk("resweep_cycles", n, DEPTH);
      fetch(8);
      chk("clear_ld_ignored", instruction, NOP);
      chk("clear_ld_valid", {31'b0, instr_valid}, 32'd1);
      fetch(0);
      chk("resweep_word0", instruction, NOP);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
